// File: rtl/riscv_mem_pkg.sv
// Shared memory-interface definitions for the fetch path.
// Access kinds, default window, fault codes and fetch state encoding.
package riscv_mem_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] DEF_START_ADDR      = 32'h0100_0000;
    localparam logic [31:0] DEF_MEM_DEPTH_BYTES = 32'h0010_0000;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_OOR      = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// First-word fall-through FIFO of fetched {pc, insn} pairs.
// Push and pop may coincide when full; flush empties it at once.
module fetch_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  fetch_entry_t      din,
    input  logic              pop,
    output fetch_entry_t      head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] step(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= step(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= step(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads main memory and queues words for
// decode; handles redirects, halts and sticky address faults.
module fetch_unit
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] START_ADDR      = DEF_START_ADDR,
    parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES,
    parameter int          BUF_DEPTH       = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [1:0]   code_d;

    logic         redir;
    logic         pop;
    logic         attempt;
    logic         misalign;
    logic         oor;
    logic         push;
    fetch_entry_t entry;
    fetch_entry_t head;
    logic [CW-1:0] count;
    logic         full;
    logic         empty;

    assign mem_address    = pc;
    assign mem_read_write = READ;
    assign entry          = '{pc: pc, insn: mem_data_out};

    assign insn_valid = !empty;
    assign insn       = empty ? '0 : head.insn;
    assign insn_pc    = empty ? '0 : head.pc;
    assign fault      = (fault_code != FAULT_NONE);

    // Subtraction wraps, so addresses below the window also fail
    assign misalign = (pc[1:0] != 2'b00);
    assign oor      = ((pc - START_ADDR) >= MEM_DEPTH_BYTES);

    always_comb begin
        redir   = redirect_valid && (state != ST_FAULT);
        pop     = insn_valid && insn_ready && !redir;
        attempt = (state == ST_FETCH) && !halt && !redir
                  && (!full || pop);
        push    = attempt && !misalign && !oor;
    end

    always_comb begin
        state_d = state;
        code_d  = fault_code;
        pc_d    = pc;
        unique case (state)
            ST_FETCH: begin
                if (attempt && (misalign || oor)) begin
                    state_d = ST_FAULT;
                    priority case (1'b1)
                        misalign: code_d = FAULT_MISALIGN;
                        default:  code_d = FAULT_OOR;
                    endcase
                end else if (halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FAULT;
        endcase
        if (redir) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= START_ADDR;
            fault_code <= FAULT_NONE;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            fault_code <= code_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .flush (redir),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assert property (@(posedge clock) disable iff (reset)
        count <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure,
// redirects, faults, halt and mid-stream reset.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        fault;
    logic [1:0]  fault_code;

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two real instructions, every other word reads as address + 'h10000000
    always_comb begin
        unique case (mem_address)
            32'h0100_0000: mem_data_out = 32'h0000_0013;
            32'h0100_0004: mem_data_out = 32'h0010_0093;
            default:       mem_data_out = mem_address + 32'h1000_0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        insn_ready     = 1'b1;
        tick(2);

        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_insn", insn, 32'h0);
        check("rst_pc", insn_pc, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_addr", mem_address, 32'h0100_0000);
        check("rw", 32'(mem_read_write), 32'd0);

        // streaming
        reset = 1'b0;
        tick();
        check("s0_valid", 32'(insn_valid), 32'd1);
        check("s0_pc", insn_pc, 32'h0100_0000);
        check("s0_insn", insn, 32'h0000_0013);
        tick();
        check("s1_pc", insn_pc, 32'h0100_0004);
        check("s1_insn", insn, 32'h0010_0093);
        tick();
        check("s2_pc", insn_pc, 32'h0100_0008);
        check("s2_insn", insn, 32'h1100_0008);

        // back-pressure
        insn_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_head", insn_pc, 32'h0100_0000);
            check("bp_valid", 32'(insn_valid), 32'd1);
        end
        check("bp_addr", mem_address, 32'h0100_0008);
        insn_ready = 1'b1;
        tick();
        check("bp_d1", insn_pc, 32'h0100_0004);
        tick();
        check("bp_d2", insn_pc, 32'h0100_0008);
        tick();
        check("bp_d3", insn_pc, 32'h0100_000C);

        // redirect while full
        insn_ready = 1'b0;
        do_reset();
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0040;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid", 32'(insn_valid), 32'd0);
        check("rd_addr", mem_address, 32'h0100_0040);
        insn_ready = 1'b1;
        tick();
        check("rd_head", insn_pc, 32'h0100_0040);
        check("rd_insn", insn, 32'h1100_0040);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0042;
        tick();
        redirect_valid = 1'b0;
        check("ma_valid0", 32'(insn_valid), 32'd0);
        tick();
        check("ma_fault", 32'(fault), 32'd1);
        check("ma_code", 32'(fault_code), 32'd1);
        check("ma_valid1", 32'(insn_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("ma_ign_addr", mem_address, 32'h0100_0042);
        check("ma_sticky", 32'(fault_code), 32'd1);
        check("ma_valid2", 32'(insn_valid), 32'd0);
        do_reset();
        check("ma_clear", 32'(fault), 32'd0);

        // window end fall-through
        redirect_valid = 1'b1;
        redirect_pc    = 32'h010F_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("end_pc", insn_pc, 32'h010F_FFFC);
        check("end_insn", insn, 32'h110F_FFFC);
        tick();
        check("end_code", 32'(fault_code), 32'd2);
        check("end_addr", mem_address, 32'h0110_0000);
        check("end_valid", 32'(insn_valid), 32'd0);

        // below the window
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00FF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("low_code", 32'(fault_code), 32'd2);
        check("low_valid", 32'(insn_valid), 32'd0);

        // halt drains buffer, pc holds, then resumes
        insn_ready = 1'b0;
        do_reset();
        tick(2);
        halt       = 1'b1;
        insn_ready = 1'b1;
        check("h_head0", insn_pc, 32'h0100_0000);
        tick();
        check("h_head1", insn_pc, 32'h0100_0004);
        tick();
        check("h_empty", 32'(insn_valid), 32'd0);
        tick();
        check("h_addr", mem_address, 32'h0100_0008);
        halt = 1'b0;
        tick();
        check("h_gap", 32'(insn_valid), 32'd0);
        tick();
        check("h_resume", insn_pc, 32'h0100_0008);
        check("h_rinsn", insn, 32'h1100_0008);
        tick();
        check("h_next", insn_pc, 32'h0100_000C);

        // reset mid-stream
        reset = 1'b1;
        tick();
        check("mr_valid", 32'(insn_valid), 32'd0);
        check("mr_addr", mem_address, 32'h0100_0000);
        reset = 1'b0;
        tick();
        check("mr_first", insn_pc, 32'h0100_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
